ctrl_ext_npc_unit: RTL and testbench

- Decode and sequencing unit of the single-cycle MIPS core; combines the main decoder (Control), the immediate extender (EXT), next-PC logic (NPC) and the PC register.
- Takes the fetched instruction, ALU zero flag and rs data; produces datapath control, the 32-bit immediate, and the current/next PC.
- Only sequential element: the PC register.

---
 rtl/ctrl_ext_npc_unit.sv | 181 ++++++++++++++++++
 tb/tb_ctrl_ext_npc_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_ext_npc_unit.sv
// Decode and sequencing unit of the single-cycle MIPS core: main decoder,
// immediate extender, next-PC selection and the PC register.
module ctrl_ext_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4,
  output logic [31:0] imm32,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic        memto_reg,
  output logic        reg_write,
  output logic        alu_src,
  output logic        alu_asrc,
  output logic        ext_op,
  output logic        shift_index,
  output logic        shift_direction,
  output logic        call,
  output logic [3:0]  alu_op,
  output logic [1:0]  npc_op
);

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_PASSA = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] br_off;

  assign op    = ins[31:26];
  assign funct = ins[5:0];

  // Main decoder; anything not listed keeps the all-zero / ADD / pc+4 defaults
  always_comb begin
    reg_dst         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    memto_reg       = 1'b0;
    reg_write       = 1'b0;
    alu_src         = 1'b0;
    alu_asrc        = 1'b0;
    ext_op          = 1'b0;
    shift_index     = 1'b0;
    shift_direction = 1'b0;
    call            = 1'b0;
    alu_op          = ALU_ADD;
    npc_op          = NPC_SEQ;
    unique case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_SUB;  end
          FN_AND:          begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_AND;  end
          FN_OR:           begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_OR;   end
          FN_XOR:          begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_XOR;  end
          FN_NOR:          begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_NOR;  end
          FN_SLT:          begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_SLT;  end
          FN_SLTU:         begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_SLTU; end
          FN_SLL, FN_SRL, FN_SLLV, FN_SRLV: begin
            reg_dst         = 1'b1;
            reg_write       = 1'b1;
            alu_asrc        = 1'b1;
            alu_op          = ALU_PASSA;
            shift_direction = funct[1];
            shift_index     = funct[2];
          end
          FN_JR:   begin reg_dst = 1'b1; npc_op = NPC_REG; end
          FN_JALR: begin reg_dst = 1'b1; npc_op = NPC_REG; call = 1'b1; reg_write = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_src = 1'b1; reg_write = 1'b1; ext_op = 1'b1; alu_op = ALU_ADD;  end
      OP_SLTI:           begin alu_src = 1'b1; reg_write = 1'b1; ext_op = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTIU:          begin alu_src = 1'b1; reg_write = 1'b1; ext_op = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:           begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_AND; end
      OP_ORI:            begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_OR;  end
      OP_XORI:           begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:            begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_LUI; end
      OP_LW: begin
        alu_src   = 1'b1;
        ext_op    = 1'b1;
        mem_read  = 1'b1;
        memto_reg = 1'b1;
        reg_write = 1'b1;
      end
      OP_SW: begin alu_src = 1'b1; ext_op = 1'b1; mem_write = 1'b1; end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        ext_op = 1'b1;
        npc_op = zero ? NPC_BR : NPC_SEQ;
      end
      OP_BNE: begin
        alu_op = ALU_SUB;
        ext_op = 1'b1;
        npc_op = zero ? NPC_SEQ : NPC_BR;
      end
      OP_J:   npc_op = NPC_JMP;
      OP_JAL: begin npc_op = NPC_JMP; call = 1'b1; reg_write = 1'b1; end
      default: ;
    endcase
  end

  // Immediate extension and next-PC selection; PC arithmetic wraps silently
  always_comb begin
    imm32    = ext_op ? {{16{ins[15]}}, ins[15:0]} : {16'h0000, ins[15:0]};
    br_off   = {{14{ins[15]}}, ins[15:0], 2'b00};
    pc_plus4 = pc_q + XLEN'(4);
    unique case (npc_op)
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = pc_plus4 + br_off;
      NPC_JMP: npc = {pc_plus4[31:28], ins[25:0], 2'b00};
      default: npc = rs_data;
    endcase
    pc_d = npc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_ctrl_ext_npc_unit.sv
// Bench for ctrl_ext_npc_unit: directed vector table, reset/PC sequences and
// random instructions checked against an instruction-level reference model.
module tb_ctrl_ext_npc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] rs_data;
  logic [31:0] pc, npc, pc_plus4, imm32;
  logic        reg_dst, mem_read, mem_write, memto_reg, reg_write, alu_src;
  logic        alu_asrc, ext_op, shift_index, shift_direction, call;
  logic [3:0]  alu_op;
  logic [1:0]  npc_op;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_ext_npc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .rs_data(rs_data),
    .pc(pc), .npc(npc), .pc_plus4(pc_plus4), .imm32(imm32),
    .reg_dst(reg_dst), .mem_read(mem_read), .mem_write(mem_write),
    .memto_reg(memto_reg), .reg_write(reg_write), .alu_src(alu_src),
    .alu_asrc(alu_asrc), .ext_op(ext_op), .shift_index(shift_index),
    .shift_direction(shift_direction), .call(call), .alu_op(alu_op),
    .npc_op(npc_op)
  );

  // Control bundle bit positions inside the 11-bit flag field
  localparam logic [10:0] F_RD   = 11'h400;
  localparam logic [10:0] F_MR   = 11'h200;
  localparam logic [10:0] F_MW   = 11'h100;
  localparam logic [10:0] F_M2R  = 11'h080;
  localparam logic [10:0] F_RW   = 11'h040;
  localparam logic [10:0] F_AS   = 11'h020;
  localparam logic [10:0] F_AAS  = 11'h010;
  localparam logic [10:0] F_EXT  = 11'h008;
  localparam logic [10:0] F_SI   = 11'h004;
  localparam logic [10:0] F_SD   = 11'h002;
  localparam logic [10:0] F_CALL = 11'h001;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] rs;
    logic        zero;
    logic [16:0] ctl;
    logic [31:0] npc;
    logic [31:0] imm;
  } vec_t;

  typedef enum {
    M_BAD, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SLLV, M_SRLV, M_JR, M_JALR, M_ADDI, M_SLTI, M_SLTIU,
    M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL
  } mn_t;

  function automatic logic [16:0] mkc(input logic [10:0] f, input logic [3:0] a,
                                      input logic [1:0] n);
    return {f, a, n};
  endfunction

  function automatic vec_t mkv(input logic [31:0] p, input logic [31:0] i,
                               input logic [31:0] r, input logic z,
                               input logic [16:0] c, input logic [31:0] nx,
                               input logic [31:0] im);
    vec_t v;
    v.pc = p; v.ins = i; v.rs = r; v.zero = z; v.ctl = c; v.npc = nx; v.imm = im;
    return v;
  endfunction

  function automatic logic [16:0] dut_ctl();
    return {reg_dst, mem_read, mem_write, memto_reg, reg_write, alu_src,
            alu_asrc, ext_op, shift_index, shift_direction, call, alu_op, npc_op};
  endfunction

  // Instruction word -> mnemonic
  function automatic mn_t classify(input logic [31:0] w);
    logic [5:0] o, f;
    o = w[31:26];
    f = w[5:0];
    if (o == 6'd0) begin
      case (f)
        6'h00: return M_SLL;   6'h02: return M_SRL;
        6'h04: return M_SLLV;  6'h06: return M_SRLV;
        6'h08: return M_JR;    6'h09: return M_JALR;
        6'h20, 6'h21: return M_ADD;
        6'h22, 6'h23: return M_SUB;
        6'h24: return M_AND;   6'h25: return M_OR;
        6'h26: return M_XOR;   6'h27: return M_NOR;
        6'h2A: return M_SLT;   6'h2B: return M_SLTU;
        default: return M_BAD;
      endcase
    end
    case (o)
      6'h02: return M_J;     6'h03: return M_JAL;
      6'h04: return M_BEQ;   6'h05: return M_BNE;
      6'h08, 6'h09: return M_ADDI;
      6'h0A: return M_SLTI;  6'h0B: return M_SLTIU;
      6'h0C: return M_ANDI;  6'h0D: return M_ORI;
      6'h0E: return M_XORI;  6'h0F: return M_LUI;
      6'h23: return M_LW;    6'h2B: return M_SW;
      default: return M_BAD;
    endcase
  endfunction

  // Mnemonic -> expected control bundle
  function automatic logic [16:0] model_ctl(input mn_t m, input logic z);
    logic [10:0] rt, it;
    rt = F_RD | F_RW;
    it = F_AS | F_RW;
    case (m)
      M_ADD:   return mkc(rt, 4'd0, 2'd0);
      M_SUB:   return mkc(rt, 4'd1, 2'd0);
      M_AND:   return mkc(rt, 4'd2, 2'd0);
      M_OR:    return mkc(rt, 4'd3, 2'd0);
      M_XOR:   return mkc(rt, 4'd4, 2'd0);
      M_NOR:   return mkc(rt, 4'd5, 2'd0);
      M_SLT:   return mkc(rt, 4'd6, 2'd0);
      M_SLTU:  return mkc(rt, 4'd7, 2'd0);
      M_SLL:   return mkc(rt | F_AAS, 4'd8, 2'd0);
      M_SRL:   return mkc(rt | F_AAS | F_SD, 4'd8, 2'd0);
      M_SLLV:  return mkc(rt | F_AAS | F_SI, 4'd8, 2'd0);
      M_SRLV:  return mkc(rt | F_AAS | F_SI | F_SD, 4'd8, 2'd0);
      M_JR:    return mkc(F_RD, 4'd0, 2'd3);
      M_JALR:  return mkc(F_RD | F_RW | F_CALL, 4'd0, 2'd3);
      M_ADDI:  return mkc(it | F_EXT, 4'd0, 2'd0);
      M_SLTI:  return mkc(it | F_EXT, 4'd6, 2'd0);
      M_SLTIU: return mkc(it | F_EXT, 4'd7, 2'd0);
      M_ANDI:  return mkc(it, 4'd2, 2'd0);
      M_ORI:   return mkc(it, 4'd3, 2'd0);
      M_XORI:  return mkc(it, 4'd4, 2'd0);
      M_LUI:   return mkc(it, 4'd9, 2'd0);
      M_LW:    return mkc(it | F_EXT | F_MR | F_M2R, 4'd0, 2'd0);
      M_SW:    return mkc(F_AS | F_EXT | F_MW, 4'd0, 2'd0);
      M_BEQ:   return mkc(F_EXT, 4'd1, z ? 2'd1 : 2'd0);
      M_BNE:   return mkc(F_EXT, 4'd1, z ? 2'd0 : 2'd1);
      M_J:     return mkc(11'h000, 4'd0, 2'd2);
      M_JAL:   return mkc(F_RW | F_CALL, 4'd0, 2'd2);
      default: return mkc(11'h000, 4'd0, 2'd0);
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w, input logic [16:0] c);
    int signed s;
    s = int'($signed(w[15:0]));
    if ((c[16:6] & F_EXT) != 11'h000) return 32'(s);
    return 32'(w[15:0]);
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w,
                                            input logic [31:0] r, input logic [1:0] sel);
    logic [31:0] seq;
    int signed s;
    seq = p + 32'd4;
    s   = int'($signed(w[15:0]));
    case (sel)
      2'd0:    return seq;
      2'd1:    return seq + 32'(s * 4);
      2'd2:    return (seq & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
      default: return r;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Steer the PC to a target by executing jr for one cycle
  task automatic set_pc(input logic [31:0] target);
    ins     = 32'h03E0_0008;
    rs_data = target;
    zero    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic [31:0] mpc;
  logic [16:0] ectl;

  initial begin
    rst = 1'b0; ins = 32'h0; zero = 1'b0; rs_data = 32'h0;

    // Reset holds PC regardless of clocking
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_hold_pc", pc, 32'h0);
    end
    rst = 1'b1;
    #1 chk("release_no_edge_pc", pc, 32'h0);
    @(posedge clk); #1;
    chk("release_1edge_pc", pc, 32'h4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("release_3edge_pc", pc, 32'hC);
    chk("nop_ctl", 32'(dut_ctl()), 32'(mkc(F_RD | F_RW | F_AAS, 4'd8, 2'd0)));
    #2 rst = 1'b0;
    #1 chk("midcycle_reset_pc", pc, 32'h0);
    @(posedge clk); #1;
    chk("reset_over_edge_pc", pc, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_pc", pc, 32'h4);

    vecs.push_back(mkv(32'h100, 32'h0000_0000, 32'h0, 1'b0, mkc(F_RD|F_RW|F_AAS, 4'd8, 2'd0), 32'h104, 32'h0));
    vecs.push_back(mkv(32'h100, 32'h2008_FFFC, 32'h0, 1'b0, mkc(F_RW|F_AS|F_EXT, 4'd0, 2'd0), 32'h104, 32'hFFFF_FFFC));
    vecs.push_back(mkv(32'h100, 32'h3508_FFFC, 32'h0, 1'b0, mkc(F_RW|F_AS, 4'd3, 2'd0), 32'h104, 32'h0000_FFFC));
    vecs.push_back(mkv(32'h10, 32'h1000_FFFF, 32'h0, 1'b1, mkc(F_EXT, 4'd1, 2'd1), 32'h10, 32'hFFFF_FFFF));
    vecs.push_back(mkv(32'h10, 32'h1000_FFFF, 32'h0, 1'b0, mkc(F_EXT, 4'd1, 2'd0), 32'h14, 32'hFFFF_FFFF));
    vecs.push_back(mkv(32'h10, 32'h1400_FFFF, 32'h0, 1'b1, mkc(F_EXT, 4'd1, 2'd0), 32'h14, 32'hFFFF_FFFF));
    vecs.push_back(mkv(32'h10, 32'h1400_FFFF, 32'h0, 1'b0, mkc(F_EXT, 4'd1, 2'd1), 32'h10, 32'hFFFF_FFFF));
    vecs.push_back(mkv(32'h20, 32'h0C00_0040, 32'h0, 1'b0, mkc(F_RW|F_CALL, 4'd0, 2'd2), 32'h100, 32'h40));
    vecs.push_back(mkv(32'h20, 32'h0800_0040, 32'h0, 1'b0, mkc(11'h000, 4'd0, 2'd2), 32'h100, 32'h40));
    vecs.push_back(mkv(32'h200, 32'h03E0_0008, 32'h48, 1'b0, mkc(F_RD, 4'd0, 2'd3), 32'h48, 32'h8));
    vecs.push_back(mkv(32'h200, 32'h03E0_F809, 32'h48, 1'b0, mkc(F_RD|F_RW|F_CALL, 4'd0, 2'd3), 32'h48, 32'hF809));
    vecs.push_back(mkv(32'h40, 32'h00A4_1004, 32'h0, 1'b0, mkc(F_RD|F_RW|F_AAS|F_SI, 4'd8, 2'd0), 32'h44, 32'h1004));
    vecs.push_back(mkv(32'h40, 32'h0004_1042, 32'h0, 1'b0, mkc(F_RD|F_RW|F_AAS|F_SD, 4'd8, 2'd0), 32'h44, 32'h1042));
    vecs.push_back(mkv(32'h40, 32'h8C88_0004, 32'h0, 1'b0, mkc(F_RW|F_AS|F_EXT|F_MR|F_M2R, 4'd0, 2'd0), 32'h44, 32'h4));
    vecs.push_back(mkv(32'h40, 32'hAC88_0004, 32'h0, 1'b0, mkc(F_AS|F_EXT|F_MW, 4'd0, 2'd0), 32'h44, 32'h4));
    vecs.push_back(mkv(32'h40, 32'hFC00_0000, 32'h0, 1'b0, mkc(11'h000, 4'd0, 2'd0), 32'h44, 32'h0));
    vecs.push_back(mkv(32'h40, 32'h3C08_1234, 32'h0, 1'b0, mkc(F_RW|F_AS, 4'd9, 2'd0), 32'h44, 32'h1234));
    vecs.push_back(mkv(32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 1'b0, mkc(F_RD|F_RW|F_AAS, 4'd8, 2'd0), 32'h0, 32'h0));
    vecs.push_back(mkv(32'h4, 32'h1000_8000, 32'h0, 1'b1, mkc(F_EXT, 4'd1, 2'd1), 32'hFFFE_0008, 32'hFFFF_8000));

    foreach (vecs[k]) begin
      set_pc(vecs[k].pc);
      ins = vecs[k].ins; rs_data = vecs[k].rs; zero = vecs[k].zero;
      #1;
      chk($sformatf("vec%0d_pc", k), pc, vecs[k].pc);
      chk($sformatf("vec%0d_pc_plus4", k), pc_plus4, vecs[k].pc + 32'd4);
      chk($sformatf("vec%0d_ctl", k), 32'(dut_ctl()), 32'(vecs[k].ctl));
      chk($sformatf("vec%0d_npc", k), npc, vecs[k].npc);
      chk($sformatf("vec%0d_imm32", k), imm32, vecs[k].imm);
    end

    // Random instruction stream, PC tracked by the model across edges
    @(posedge clk); #1;
    mpc = pc;
    for (int it = 0; it < 400; it++) begin
      logic [5:0] ops [18];
      logic [5:0] fns [17];
      logic [31:0] w;
      mn_t m;
      ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
              6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
      fns = '{6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
              6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 17)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 9) != 0) w[5:0] = fns[$urandom_range(0, 16)];
      ins = w;
      zero = 1'($urandom_range(0, 1));
      rs_data = $urandom;
      #1;
      m = classify(w);
      ectl = model_ctl(m, zero);
      chk("rnd_pc", pc, mpc);
      chk("rnd_pc_plus4", pc_plus4, mpc + 32'd4);
      chk("rnd_ctl", 32'(dut_ctl()), 32'(ectl));
      chk("rnd_imm32", imm32, model_imm(w, ectl));
      chk("rnd_npc", npc, model_npc(mpc, w, rs_data, ectl[1:0]));
      mpc = model_npc(mpc, w, rs_data, ectl[1:0]);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
